spi_keys: RTL and testbench



---
 rtl/spi_keys.sv | 134 +++++++++++++
 tb/tb_spi_keys.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_keys.sv
// spi_keys
//
// SPI slave (mode 0) that reports the state of one key per 8-bit frame.
// The master shifts in an 8-bit key index, MSB first. After the eighth SCK
// rising edge, MISO carries the pressed/released bit of that key. The bit is
// taken from a snapshot of the key bank that is captured when CS falls.
// All SPI pins and key inputs are oversampled by the system clock.
//
// Ports:
//   clk_g_i       system clock; every flop runs on it
//   rst_g_i       asynchronous, active-high reset
//   spi_clk_g_i   SCK from the master (idle low, sampled on the rising edge)
//   spi_mosi_g_i  key index from the master, MSB first
//   spi_miso_g_o  state of the addressed key (0 while CS is high)
//   spi_cs_g_i    chip select, active low
//   keys_i_g      raw key states, bit n = key n, 1 = pressed
//
// Parameter:
//   NUM_KEYS      number of key inputs, 1..256

module spi_keys #(
  parameter int NUM_KEYS = 89
) (
  input  logic                clk_g_i,
  input  logic                rst_g_i,
  input  logic                spi_clk_g_i,
  input  logic                spi_mosi_g_i,
  output logic                spi_miso_g_o,
  input  logic                spi_cs_g_i,
  input  logic [NUM_KEYS-1:0] keys_i_g
);

  logic [1:0]          sck_sync;
  logic [1:0]          mosi_sync;
  logic [1:0]          cs_sync;
  logic [NUM_KEYS-1:0] keys_meta;
  logic [NUM_KEYS-1:0] keys_sync;
  logic [NUM_KEYS-1:0] snapshot;

  logic                sck_prev;
  logic                cs_prev;
  logic                sck_rise;
  logic                cs_fall;
  logic                mosi_bit;

  logic [2:0]          bit_cnt;
  logic [6:0]          shift;
  logic [7:0]          index;
  logic [255:0]        snap_ext;
  logic                reply;

  // Two-flop synchronisers for every asynchronous input. The CS chain
  // resets to 1 so that releasing reset while CS is high does not look
  // like a CS falling edge.
  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      keys_meta <= '0;
      keys_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_clk_g_i};
      mosi_sync <= {mosi_sync[0], spi_mosi_g_i};
      cs_sync   <= {cs_sync[0], spi_cs_g_i};
      keys_meta <= keys_i_g;
      keys_sync <= keys_meta;
    end
  end

  // Edge detection. The detected pulses are registered, and MOSI is delayed
  // along with them. The bit that is shifted in is therefore the MOSI value
  // that was present when the rising edge was seen. This registration stage
  // is the "edge detect" cycle in the four-cycle pin-to-MISO latency.
  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
      sck_rise <= 1'b0;
      cs_fall  <= 1'b0;
      mosi_bit <= 1'b0;
    end else begin
      sck_prev <= sck_sync[1];
      cs_prev  <= cs_sync[1];
      sck_rise <= sck_sync[1] & ~sck_prev;
      cs_fall  <= cs_prev & ~cs_sync[1];
      mosi_bit <= mosi_sync[1];
    end
  end

  // The key bank is frozen at the start of each CS-low period. Every reply
  // in that transaction comes from this copy.
  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      snapshot <= '0;
    end else if (cs_fall) begin
      snapshot <= keys_sync;
    end
  end

  // The shift register holds the first seven bits of a frame. The eighth
  // bit comes straight from MOSI to complete the index. The snapshot is
  // zero-padded to the full 8-bit index space, so an index at or beyond
  // NUM_KEYS reads back 0 without a separate range compare.
  always_comb begin
    index                   = {shift, mosi_bit};
    snap_ext                = '0;
    snap_ext[NUM_KEYS-1:0]  = snapshot;
    reply                   = snap_ext[index];
  end

  // Frame engine. CS high discards any partial frame and forces MISO low.
  // While CS is low, each SCK rise shifts in one bit. On the 8th rise the
  // counter wraps, MISO is updated, and the next frame starts at once.
  // MISO then holds its value until the next 8th rise.
  always_ff @(posedge clk_g_i or posedge rst_g_i) begin
    if (rst_g_i) begin
      bit_cnt      <= 3'd0;
      shift        <= 7'd0;
      spi_miso_g_o <= 1'b0;
    end else if (cs_sync[1]) begin
      bit_cnt      <= 3'd0;
      shift        <= 7'd0;
      spi_miso_g_o <= 1'b0;
    end else if (sck_rise) begin
      shift   <= index[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        spi_miso_g_o <= reply;
      end
    end
  end

endmodule

// File: tb/tb_spi_keys.sv
// tb_spi_keys
//
// Bench for spi_keys with NUM_KEYS = 89. It uses three kinds of stimulus:
// a table of single-frame transactions with fixed expected replies,
// hand-written sequences for the multi-cycle corner cases, and randomised
// transactions. The randomised expected replies come from a simple model:
// the key pattern present at CS fall, indexed by the frame value, and 0 for
// an index past the last key.

module tb_spi_keys;

  localparam int NK      = 89;
  localparam int FAST_NS = 128;
  localparam int SWEEP_NS = 500;

  logic          clk;
  logic          rst;
  logic          sck;
  logic          mosi;
  logic          miso;
  logic          cs;
  logic [NK-1:0] keys;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [NK-1:0] keys;
    logic [7:0]    idx;
    logic          exp;
  } vec_t;

  vec_t tv[8];

  spi_keys #(.NUM_KEYS(NK)) dut (
    .clk_g_i      (clk),
    .rst_g_i      (rst),
    .spi_clk_g_i  (sck),
    .spi_mosi_g_i (mosi),
    .spi_miso_g_o (miso),
    .spi_cs_g_i   (cs),
    .keys_i_g     (keys)
  );

  // 16 ns system clock
  initial begin
    clk = 1'b0;
    forever #8 clk = ~clk;
  end

  // Expected reply: the captured pattern bit, or 0 past the last key.
  function automatic logic model(input logic [NK-1:0] pat, input int idx);
    if (idx < NK) return pat[idx];
    return 1'b0;
  endfunction

  function automatic logic [NK-1:0] rand_keys();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NK-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic exp);
    @(negedge clk);
    n_checks++;
    if (miso !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: miso=%b expected %b", name, miso, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] val, input int n, input int half_ns);
    for (int b = 7; b > 7 - n; b--) begin
      mosi = val[b];
      #(half_ns);
      sck = 1'b1;
      #(half_ns);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] val, input int half_ns);
    send_bits(val, 8, half_ns);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k, input logic [7:0] idx);
    keys = k;
    repeat (6) @(posedge clk);
    cs_low();
    send_frame(idx, FAST_NS);
  endtask

  initial begin
    logic [NK-1:0] pat;
    logic [NK-1:0] ones;
    logic [NK-1:0] onehot;
    logic [7:0]    idx;
    logic          exp;
    n_checks = 0;
    n_fail   = 0;
    ones     = '1;

    tv[0] = '{keys: NK'(1) << 5,  idx: 8'h05, exp: 1'b1};
    tv[1] = '{keys: NK'(1) << 5,  idx: 8'h06, exp: 1'b0};
    tv[2] = '{keys: ones,         idx: 8'h59, exp: 1'b0};
    tv[3] = '{keys: ones,         idx: 8'hFF, exp: 1'b0};
    tv[4] = '{keys: ones,         idx: 8'h58, exp: 1'b1};
    tv[5] = '{keys: ones,         idx: 8'h00, exp: 1'b1};
    tv[6] = '{keys: '0,           idx: 8'h00, exp: 1'b0};
    tv[7] = '{keys: ~(NK'(1) << 40), idx: 8'd40, exp: 1'b0};

    // Reset, then idle with CS high: SCK activity must not change MISO.
    rst  = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    cs   = 1'b1;
    keys = ones;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    checkOutput("reset_idle", 1'b0);
    send_frame(8'hFF, FAST_NS);
    checkOutput("idle_sck_ignored", 1'b0);

    // Single read and a second frame in the same CS period.
    onehot = NK'(1) << 5;
    applyStimulus(onehot, 8'h05);
    checkOutput("single_read_5", 1'b1);
    send_frame(8'h06, FAST_NS);
    checkOutput("same_cs_read_6", 1'b0);

    // MISO holds its value through the next frame, then returns to 0 on CS rise.
    send_frame(8'h05, FAST_NS);
    checkOutput("reread_5", 1'b1);
    send_bits(8'h06, 7, FAST_NS);
    checkOutput("hold_during_frame", 1'b1);
    send_bits(8'h0C, 1, FAST_NS);
    checkOutput("after_8th_edge", 1'b0);
    send_frame(8'h05, FAST_NS);
    checkOutput("read_5_before_cs_rise", 1'b1);
    cs_high();
    checkOutput("cs_rise_clears", 1'b0);

    // The snapshot hides a key change made after CS falls.
    onehot = NK'(1) << 3;
    keys = onehot;
    repeat (6) @(posedge clk);
    cs_low();
    keys = '0;
    send_frame(8'h03, FAST_NS);
    checkOutput("snapshot_old", 1'b1);
    cs_high();
    cs_low();
    send_frame(8'h03, FAST_NS);
    checkOutput("snapshot_new", 1'b0);
    cs_high();

    // An aborted partial frame leaves no residue.
    keys = NK'(1) << 2;
    repeat (6) @(posedge clk);
    cs_low();
    send_bits(8'h00, 4, FAST_NS);
    cs_high();
    checkOutput("abort_miso_low", 1'b0);
    cs_low();
    send_frame(8'h02, FAST_NS);
    checkOutput("after_abort_read_2", 1'b1);

    // Reset in the middle of a frame clears MISO immediately.
    send_bits(8'h02, 3, FAST_NS);
    rst = 1'b1;
    #20;
    checkOutput("reset_mid_frame", 1'b0);
    rst = 1'b0;
    cs_high();
    cs_low();
    send_frame(8'h02, FAST_NS);
    checkOutput("after_reset_read_2", 1'b1);
    cs_high();

    // Table of single-frame transactions.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tv[i].keys, tv[i].idx);
      checkOutput($sformatf("table_%0d_idx_%0d", i, tv[i].idx), tv[i].exp);
      cs_high();
    end

    // Randomised transactions. Keys change at random while CS is low.
    for (int t = 0; t < 4; t++) begin
      pat = rand_keys();
      keys = pat;
      repeat (6) @(posedge clk);
      cs_low();
      keys = rand_keys();
      for (int f = 0; f < 8; f++) begin
        idx = 8'($urandom_range(0, 120));
        if (f == 7) idx = 8'($urandom_range(0, 255));
        exp = model(pat, int'(idx));
        send_frame(idx, FAST_NS);
        checkOutput($sformatf("rand_t%0d_f%0d_idx_%0d", t, f, idx), exp);
      end
      cs_high();
      checkOutput($sformatf("rand_t%0d_cs_high", t), 1'b0);
    end

    // Full sweep of all keys, back-to-back at a 1000 ns SCK period.
    pat = rand_keys();
    keys = pat;
    repeat (6) @(posedge clk);
    cs_low();
    for (int i = 0; i < NK; i++) begin
      send_frame(8'(i), SWEEP_NS);
      checkOutput($sformatf("sweep_idx_%0d", i), model(pat, i));
    end
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
